// File: rtl/i2c_bus_conditioner.sv
// ---------------------------------------------------------------------------
// i2c_bus_conditioner
// Cleans the raw I2C pad inputs before they reach the slave bit engine.
// Each line is synchronised to clk and run through a filter that needs a
// run of identical samples before it changes level. From the filtered
// levels it derives one-cycle SCL edge strobes, START/STOP strobes and a
// bus-busy flag. A watchdog ends a transaction when SCL is held low too long.
//
// Ports:
//   clk       system clock
//   rst       synchronous reset, active high
//   scl_i     raw SCL pad input (asynchronous)
//   sda_i     raw SDA pad input (asynchronous)
//   scl_f     filtered SCL level
//   sda_f     filtered SDA level
//   scl_rise  one-cycle strobe, scl_f went 0->1
//   scl_fall  one-cycle strobe, scl_f went 1->0
//   start     one-cycle strobe, START or repeated START
//   stop      one-cycle strobe, STOP
//   busy      bus owned between START and STOP/timeout
//   timeout   one-cycle strobe, SCL-low timeout fired
// ---------------------------------------------------------------------------
module i2c_bus_conditioner #(
   parameter int SYNC_STAGES    = 2,
   parameter int FILTER_LEN     = 3,
   parameter int TIMEOUT_CYCLES = 1000,
   parameter int TO_W           = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic scl_i,
   input  logic sda_i,
   output logic scl_f,
   output logic sda_f,
   output logic scl_rise,
   output logic scl_fall,
   output logic start,
   output logic stop,
   output logic busy,
   output logic timeout
);

   localparam int              FC_W     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [FC_W-1:0] FC_LAST  = FC_W'(FILTER_LEN - 1);
   localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES);
   localparam logic [TO_W-1:0] TO_PRE   = TO_W'(TIMEOUT_CYCLES - 1);
   localparam bit              TO_EN    = (TIMEOUT_CYCLES != 0);

   logic [SYNC_STAGES-1:0] scl_sync_r, sda_sync_r;
   logic [FC_W-1:0]        scl_cnt_r, sda_cnt_r;
   logic [FC_W-1:0]        scl_cnt_nxt_s, sda_cnt_nxt_s;
   logic [TO_W-1:0]        to_cnt_r, to_cnt_nxt_s;
   logic scl_f_r, sda_f_r;
   logic scl_rise_r, scl_fall_r, start_r, stop_r, busy_r, timeout_r, armed_r;
   logic scl_s, sda_s;
   logic scl_upd_s, sda_upd_s;
   logic start_nxt_s, stop_nxt_s, to_fire_s;

   assign scl_s = scl_sync_r[SYNC_STAGES-1];
   assign sda_s = sda_sync_r[SYNC_STAGES-1];

   // Filter decisions, bus condition detection and watchdog next-state.
   always_comb begin
      scl_upd_s     = (scl_s != scl_f_r) && (scl_cnt_r == FC_LAST);
      sda_upd_s     = (sda_s != sda_f_r) && (sda_cnt_r == FC_LAST);
      scl_cnt_nxt_s = {FC_W{1'b0}};
      sda_cnt_nxt_s = {FC_W{1'b0}};
      if ((scl_s == scl_f_r) || scl_upd_s) begin
         scl_cnt_nxt_s = {FC_W{1'b0}};
      end else begin
         scl_cnt_nxt_s = scl_cnt_r + FC_W'(1);
      end
      if ((sda_s == sda_f_r) || sda_upd_s) begin
         sda_cnt_nxt_s = {FC_W{1'b0}};
      end else begin
         sda_cnt_nxt_s = sda_cnt_r + FC_W'(1);
      end

      // SDA edge only counts as START/STOP when SCL is steadily high;
      // a simultaneous SCL update is treated as a clock edge instead.
      start_nxt_s = armed_r && sda_upd_s && !sda_s && scl_f_r && !scl_upd_s;
      stop_nxt_s  = armed_r && sda_upd_s &&  sda_s && scl_f_r && !scl_upd_s;

      to_cnt_nxt_s = {TO_W{1'b0}};
      to_fire_s    = 1'b0;
      if (!TO_EN) begin
         to_cnt_nxt_s = {TO_W{1'b0}};
         to_fire_s    = 1'b0;
      end else if (!busy_r || scl_upd_s || scl_f_r || start_nxt_s) begin
         to_cnt_nxt_s = {TO_W{1'b0}};
         to_fire_s    = 1'b0;
      end else if (to_cnt_r == TO_LIMIT) begin
         // saturated: the single timeout has already fired
         to_cnt_nxt_s = to_cnt_r;
         to_fire_s    = 1'b0;
      end else begin
         to_cnt_nxt_s = to_cnt_r + TO_W'(1);
         to_fire_s    = (to_cnt_r == TO_PRE);
      end
   end

   // All state: synchronisers, filters, strobes, busy, armed and watchdog.
   always_ff @(posedge clk) begin
      if (rst) begin
         scl_sync_r <= {SYNC_STAGES{1'b1}};
         sda_sync_r <= {SYNC_STAGES{1'b1}};
         scl_cnt_r  <= {FC_W{1'b0}};
         sda_cnt_r  <= {FC_W{1'b0}};
         scl_f_r    <= 1'b1;
         sda_f_r    <= 1'b1;
         scl_rise_r <= 1'b0;
         scl_fall_r <= 1'b0;
         start_r    <= 1'b0;
         stop_r     <= 1'b0;
         timeout_r  <= 1'b0;
         busy_r     <= 1'b0;
         armed_r    <= 1'b0;
         to_cnt_r   <= {TO_W{1'b0}};
      end else begin
         scl_sync_r <= {scl_sync_r[SYNC_STAGES-2:0], scl_i};
         sda_sync_r <= {sda_sync_r[SYNC_STAGES-2:0], sda_i};
         scl_cnt_r  <= scl_cnt_nxt_s;
         sda_cnt_r  <= sda_cnt_nxt_s;
         if (scl_upd_s) begin
            scl_f_r <= scl_s;
         end
         if (sda_upd_s) begin
            sda_f_r <= sda_s;
         end
         scl_rise_r <= scl_upd_s &&  scl_s;
         scl_fall_r <= scl_upd_s && !scl_s;
         start_r    <= start_nxt_s;
         stop_r     <= stop_nxt_s;
         timeout_r  <= to_fire_s;
         // busy follows the registered strobes; START beats STOP/timeout
         if (start_r) begin
            busy_r <= 1'b1;
         end else if (stop_r || timeout_r) begin
            busy_r <= 1'b0;
         end
         // an idle-looking bus seen once is enough to trust SDA edges
         if (scl_s && sda_s) begin
            armed_r <= 1'b1;
         end
         to_cnt_r <= to_cnt_nxt_s;
      end
   end

   assign scl_f    = scl_f_r;
   assign sda_f    = sda_f_r;
   assign scl_rise = scl_rise_r;
   assign scl_fall = scl_fall_r;
   assign start    = start_r;
   assign stop     = stop_r;
   assign busy     = busy_r;
   assign timeout  = timeout_r;

endmodule

// File: tb/tb_i2c_bus_conditioner.sv
module tb_i2c_bus_conditioner;

   localparam int S = 2;
   localparam int L = 3;
   localparam int T = 1000;

   logic clk = 1'b0;
   logic rst, scl_i, sda_i;
   logic scl_f, sda_f, scl_rise, scl_fall, start, stop, busy, timeout;

   i2c_bus_conditioner #(
      .SYNC_STAGES(S), .FILTER_LEN(L), .TIMEOUT_CYCLES(T), .TO_W(16)
   ) dut (
      .clk(clk), .rst(rst), .scl_i(scl_i), .sda_i(sda_i),
      .scl_f(scl_f), .sda_f(sda_f), .scl_rise(scl_rise), .scl_fall(scl_fall),
      .start(start), .stop(stop), .busy(busy), .timeout(timeout)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;

   // reference model: pin history since reset, expected outputs
   bit pscl[$];
   bit psda[$];
   int k;
   int m_clr;
   bit m_scl_f, m_sda_f, m_armed, m_busy;
   bit m_rise, m_fall, m_start, m_stop, m_to;

   // observed event log for directed checks
   int ev_start, ev_stop, ev_fall, ev_rise, ev_to, ev_busy_on, ev_busy_off;
   int n_start, n_stop, n_fall, n_rise, n_to;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s at k=%0d: got %b expected %b", tag, k, obs, exp);
      end
   endtask

   task automatic chki(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   // synchronised sample seen by the filter at edge kk
   function automatic bit syn(input bit is_scl, input int kk);
      if (kk < S + 1) return 1'b1;
      return is_scl ? pscl[kk-S-1] : psda[kk-S-1];
   endfunction

   // a filtered level flips when the last L synchronised samples all differ from it
   function automatic bit flips(input bit is_scl, input bit f);
      for (int j = 0; j < L; j++) begin
         if (syn(is_scl, k - j) == f) return 1'b0;
      end
      return 1'b1;
   endfunction

   task automatic model_edge(input bit r, input bit c, input bit d);
      bit uc, ud, ns, np, nt, nb;
      if (r) begin
         pscl.delete(); psda.delete();
         k = 0; m_clr = 0;
         m_scl_f = 1'b1; m_sda_f = 1'b1; m_armed = 1'b0; m_busy = 1'b0;
         m_rise = 1'b0; m_fall = 1'b0; m_start = 1'b0; m_stop = 1'b0; m_to = 1'b0;
      end else begin
         pscl.push_back(c); psda.push_back(d);
         k = pscl.size();
         uc = flips(1'b1, m_scl_f);
         ud = flips(1'b0, m_sda_f);
         ns = m_armed && ud &&  m_sda_f && m_scl_f && !uc;
         np = m_armed && ud && !m_sda_f && m_scl_f && !uc;
         nt = 1'b0;
         if (!m_busy || uc || m_scl_f || ns) m_clr = k;
         else if (k - m_clr == T) nt = 1'b1;
         nb = m_start ? 1'b1 : ((m_stop || m_to) ? 1'b0 : m_busy);
         m_armed = m_armed || (syn(1'b1, k) && syn(1'b0, k));
         m_rise = uc && !m_scl_f;
         m_fall = uc &&  m_scl_f;
         if (uc) m_scl_f = !m_scl_f;
         if (ud) m_sda_f = !m_sda_f;
         m_start = ns; m_stop = np; m_to = nt; m_busy = nb;
      end
   endtask

   task automatic clr_ev();
      ev_start = 0; ev_stop = 0; ev_fall = 0; ev_rise = 0; ev_to = 0;
      ev_busy_on = 0; ev_busy_off = 0;
      n_start = 0; n_stop = 0; n_fall = 0; n_rise = 0; n_to = 0;
   endtask

   // one clock: drive pins, step model, compare every output
   task automatic cyc(input bit r, input bit c, input bit d);
      bit busy_prev;
      busy_prev = busy;
      rst = r; scl_i = c; sda_i = d;
      @(posedge clk);
      model_edge(r, c, d);
      #1;
      chk1("scl_f", scl_f, m_scl_f);
      chk1("sda_f", sda_f, m_sda_f);
      chk1("scl_rise", scl_rise, m_rise);
      chk1("scl_fall", scl_fall, m_fall);
      chk1("start", start, m_start);
      chk1("stop", stop, m_stop);
      chk1("busy", busy, m_busy);
      chk1("timeout", timeout, m_to);
      if (!r) begin
         if (start === 1'b1) begin ev_start = k; n_start++; end
         if (stop === 1'b1) begin ev_stop = k; n_stop++; end
         if (scl_fall === 1'b1) begin ev_fall = k; n_fall++; end
         if (scl_rise === 1'b1) begin ev_rise = k; n_rise++; end
         if (timeout === 1'b1) begin ev_to = k; n_to++; end
         if (busy === 1'b1 && busy_prev !== 1'b1) ev_busy_on = k;
         if (busy !== 1'b1 && busy_prev === 1'b1) ev_busy_off = k;
      end
   endtask

   task automatic hold(input bit c, input bit d, input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, c, d);
   endtask

   initial begin
      rst = 1'b1; scl_i = 1'b1; sda_i = 1'b1;
      // reset and idle bus
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      clr_ev();
      hold(1'b1, 1'b1, 10);
      chki("idle_no_strobes", n_start + n_stop + n_fall + n_rise + n_to, 0);

      // START then STOP, latency SYNC+FILTER
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      clr_ev();
      hold(1'b1, 1'b1, 10);
      hold(1'b1, 1'b0, 20);
      chki("start_cycle", ev_start, 15);
      chki("busy_on_cycle", ev_busy_on, 16);
      hold(1'b1, 1'b1, 10);
      chki("stop_cycle", ev_stop, 35);
      chki("busy_off_cycle", ev_busy_off, 36);
      chki("start_count", n_start, 1);

      // glitch filtering on SCL
      clr_ev();
      hold(1'b1, 1'b1, 5);
      hold(1'b0, 1'b1, 2);
      hold(1'b1, 1'b1, 10);
      chki("glitch2_edges", n_fall + n_rise, 0);
      hold(1'b0, 1'b1, 3);
      hold(1'b1, 1'b1, 10);
      chki("glitch3_fall", n_fall, 1);
      chki("glitch3_rise_gap", ev_rise - ev_fall, 3);
      chki("glitch_no_cond", n_start + n_stop, 0);

      // both lines low through reset release
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      clr_ev();
      hold(1'b0, 1'b0, 10);
      hold(1'b1, 1'b0, 10);
      chki("stuck_low_no_start", n_start, 0);
      hold(1'b1, 1'b1, 10);
      chki("stop_while_idle", ev_stop, 25);
      chk1("stop_idle_busy", busy, 1'b0);
      hold(1'b1, 1'b0, 10);
      chki("second_edge_start", ev_start, 35);
      hold(1'b1, 1'b1, 10);

      // simultaneous SCL/SDA change with SCL high
      clr_ev();
      hold(1'b0, 1'b0, 10);
      chki("simul_fall", n_fall, 1);
      chki("simul_no_cond", n_start + n_stop, 0);
      hold(1'b1, 1'b1, 10);
      chki("simul_rise", n_rise, 1);
      chki("simul_no_cond2", n_start + n_stop, 0);

      // SCL-low timeout
      cyc(1'b1, 1'b1, 1'b1);
      clr_ev();
      hold(1'b1, 1'b1, 10);
      hold(1'b1, 1'b0, 10);
      hold(1'b0, 1'b0, 1100);
      chki("timeout_count", n_to, 1);
      chki("timeout_distance", ev_to - ev_fall, T);
      chki("timeout_busy_off", ev_busy_off, ev_to + 1);
      chk1("timeout_busy_now", busy, 1'b0);
      hold(1'b1, 1'b0, 10);
      hold(1'b1, 1'b1, 10);

      // randomized pins with occasional mid-stream reset
      for (int i = 0; i < 1500; i++) begin
         bit c, d, r;
         int n;
         c = 1'($urandom_range(1, 0));
         d = 1'($urandom_range(1, 0));
         r = ($urandom_range(59, 0) == 0);
         n = int'($urandom_range(5, 1));
         if (r) cyc(1'b1, c, d);
         else hold(c, d, n);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
